// File: rtl/ahb_lite_traffic_gen.sv
// AHB-Lite soak master: writes a selectable pattern across an address window,
// reads it back, and reports mismatches and bus errors for each pass.
module ahb_lite_traffic_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_BEATS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       SEED      = 32'hACE1,
    parameter int                CNT_W     = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              bus_err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int SIZE_V = $clog2(BYTES);
    localparam int KW     = $clog2(NUM_BEATS + 1);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_BEATS - 1);
    localparam logic [31:0]   TAPS   = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WA,
        S_WD,
        S_RA,
        S_RD,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k, k_nxt;
    logic [31:0]         lfsr, lfsr_nxt;
    logic [1:0]          mode_q, mode_nxt;
    logic [CNT_W-1:0]    err_nxt;
    logic [ADDR_W-1:0]   fea_nxt;
    logic                bus_err_nxt;
    logic                pass_nxt;
    logic [ADDR_W-1:0]   addr_k;
    logic [DATA_W-1:0]   pattern;
    logic                last_beat;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    assign addr_k    = BASE_ADDR + (ADDR_W'(k) << SIZE_V);
    assign last_beat = (k == LAST_K);

    always_comb begin
        pattern = '0;
        case (mode_q)
            2'd0: pattern = DATA_W'(lfsr);
            2'd1: pattern = DATA_W'(addr_k);
            2'd2: pattern = {{(DATA_W-1){1'b0}}, 1'b1} << (32'(k) % DATA_W);
            2'd3: pattern = k[0] ? '0 : '1;
            default: pattern = '0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        lfsr_nxt    = lfsr;
        mode_nxt    = mode_q;
        err_nxt     = err_count;
        fea_nxt     = first_err_addr;
        bus_err_nxt = bus_err;
        pass_nxt    = pass;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_WA;
                    k_nxt       = '0;
                    lfsr_nxt    = SEED;
                    mode_nxt    = mode;
                    err_nxt     = '0;
                    fea_nxt     = '0;
                    bus_err_nxt = 1'b0;
                    pass_nxt    = 1'b0;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WA: begin
                if (HREADY) state_nxt = S_WD;
            end
            S_WD: begin
                if (HRESP) bus_err_nxt = 1'b1;
                if (HREADY) begin
                    if (last_beat) begin
                        state_nxt = S_RA;
                        k_nxt     = '0;
                        lfsr_nxt  = SEED;
                    end else begin
                        state_nxt = S_WA;
                        k_nxt     = k + 1'b1;
                        lfsr_nxt  = lfsr_step(lfsr);
                    end
                end
            end
            S_RA: begin
                if (HREADY) state_nxt = S_RD;
            end
            S_RD: begin
                if (HRESP) bus_err_nxt = 1'b1;
                if (HREADY) begin
                    // An errored beat carries no valid data, so it is not compared.
                    if (!HRESP && (HRDATA != pattern)) begin
                        if (err_count == '0) fea_nxt = addr_k;
                        if (err_count != '1) err_nxt = err_count + 1'b1;
                    end
                    if (last_beat) begin
                        state_nxt = S_DONE;
                        pass_nxt  = (err_nxt == '0) && !bus_err_nxt;
                    end else begin
                        state_nxt = S_RA;
                        k_nxt     = k + 1'b1;
                        lfsr_nxt  = lfsr_step(lfsr);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state          <= S_IDLE;
            k              <= '0;
            lfsr           <= SEED;
            mode_q         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            bus_err        <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            k              <= k_nxt;
            lfsr           <= lfsr_nxt;
            mode_q         <= mode_nxt;
            err_count      <= err_nxt;
            first_err_addr <= fea_nxt;
            bus_err        <= bus_err_nxt;
            pass           <= pass_nxt;
        end
    end

    assign busy      = (state == S_WA) || (state == S_WD) || (state == S_RA) || (state == S_RD);
    assign done      = (state == S_DONE);
    assign HTRANS    = ((state == S_WA) || (state == S_RA)) ? 2'b10 : 2'b00;
    assign HADDR     = busy ? addr_k : '0;
    assign HWRITE    = (state == S_WA) || (state == S_WD);
    assign HWDATA    = (state == S_WD) ? pattern : '0;
    assign HSIZE     = 3'(SIZE_V);
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// Directed bench: RAM slave with configurable waits/errors/bit flips, plus a
// second always-zero slave instance for the err_count saturation case.
module tb_ahb_lite_traffic_gen;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy, done, pass, bus_err;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    logic        start2 = 1'b0;
    logic [31:0] haddr2, hwdata2, fea2;
    logic [1:0]  htrans2;
    logic        hwrite2, hmastlock2, busy2, done2, pass2, bus_err2;
    logic [2:0]  hsize2, hburst2;
    logic [3:0]  hprot2;
    logic [3:0]  err_count2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_traffic_gen #(.NUM_BEATS(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .bus_err(bus_err)
    );

    ahb_lite_traffic_gen #(.NUM_BEATS(20), .CNT_W(4), .BASE_ADDR(32'h100)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start2), .mode(2'd2),
        .HADDR(haddr2), .HTRANS(htrans2), .HWRITE(hwrite2), .HSIZE(hsize2),
        .HBURST(hburst2), .HPROT(hprot2), .HMASTLOCK(hmastlock2), .HWDATA(hwdata2),
        .HRDATA(32'h0), .HREADY(1'b1), .HRESP(1'b0), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err_count2), .first_err_addr(fea2),
        .bus_err(bus_err2)
    );

    // RAM slave: 16 words at address 0; waits/err/flip set by the tests.
    logic [31:0] mem [16];
    int          waits = 0;
    int          err_wbeat = -1;
    int          flip_rbeat = -1;
    logic        clr = 1'b0;
    logic        dp_active = 1'b0;
    logic        dp_write = 1'b0;
    logic        dp_err = 1'b0;
    logic [3:0]  dp_idx = '0;
    int          wait_cnt = 0;

    assign HREADY = !dp_active || (wait_cnt == 0);
    assign HRESP  = dp_active && dp_err && (wait_cnt <= 1);
    assign HRDATA = (dp_active && !dp_write)
                    ? (mem[dp_idx] ^ ((flip_rbeat >= 0 && dp_idx == 4'(flip_rbeat)) ? 32'h1 : 32'h0))
                    : 32'h0;

    always @(posedge HCLK) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end
        if (HRESET) begin
            dp_active <= 1'b0;
            wait_cnt  <= 0;
        end else begin
            if (dp_active) begin
                if (wait_cnt > 0) begin
                    wait_cnt <= wait_cnt - 1;
                end else begin
                    if (dp_write && !dp_err) mem[dp_idx] <= HWDATA;
                    dp_active <= 1'b0;
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                dp_active <= 1'b1;
                dp_write  <= HWRITE;
                dp_idx    <= HADDR[5:2];
                dp_err    <= HWRITE && (err_wbeat >= 0) && (HADDR[5:2] == 4'(err_wbeat));
                wait_cnt  <= (HWRITE && (err_wbeat >= 0) && (HADDR[5:2] == 4'(err_wbeat))) ? waits + 1 : waits;
            end
        end
    end

    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    always @(posedge HCLK) begin
        if (!HRESET && HTRANS == 2'b10 && HREADY) begin
            if (HWRITE) wr_cnt <= wr_cnt + 1;
            else        rd_cnt <= rd_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic clear_mem();
        @(negedge HCLK); clr = 1'b1;
        @(negedge HCLK); clr = 1'b0;
    endtask

    // Starts a pass on the main DUT and waits for done; mode input is disturbed
    // after the start cycle and start is optionally re-pulsed while busy.
    task automatic run_pass(input logic [1:0] m, input int restart_at,
                            output int cycles, output int unstable);
        logic [31:0] pa, pw;
        logic [1:0]  pt;
        logic        ph;
        @(negedge HCLK);
        start = 1'b1; mode = m;
        cycles = 0; unstable = 0; ph = 1'b1; pa = '0; pw = '0; pt = '0;
        while (cycles < 3000) begin
            @(negedge HCLK);
            cycles++;
            start = (restart_at > 0 && cycles == restart_at);
            mode  = m ^ 2'b01;
            if (!HREADY && !ph && (HADDR !== pa || HTRANS !== pt || HWDATA !== pw)) unstable++;
            pa = HADDR; pt = HTRANS; pw = HWDATA; ph = HREADY;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %b expected 00", HTRANS); end
        n_checks++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h expected 0", HADDR); end
        n_checks++; if (HWRITE !== 1'b0 || HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_write: got %b/%h expected 0/0", HWRITE, HWDATA); end
        n_checks++; if ({busy, done, pass, bus_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, bus_err}); end
        n_checks++; if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err: got %h/%h expected 0/0", err_count, first_err_addr); end
        n_checks++; if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'd2, 3'd0, 4'b0011, 1'b0}) begin n_fail++; $display("FAIL reset_consts: got %b expected 010000000110", {HSIZE, HBURST, HPROT, HMASTLOCK}); end
        @(negedge HCLK); HRESET = 1'b0;
    endtask

    task automatic test_lfsr_pass();
        int cyc, uns, w0, r0, d0;
        logic [31:0] s;
        waits = 0; err_wbeat = -1; flip_rbeat = -1;
        clear_mem();
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        run_pass(2'd0, 0, cyc, uns);
        n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL lfsr_cycles: got %0d expected 65", cyc); end
        n_checks++; if (pass !== 1'b1 || err_count !== 16'h0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL lfsr_result: got pass=%b err=%0d berr=%b expected 1/0/0", pass, err_count, bus_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lfsr_busy_at_done: got %b expected 0", busy); end
        @(negedge HCLK);
        n_checks++; if (done !== 1'b0 || pass !== 1'b1) begin n_fail++; $display("FAIL lfsr_done_pulse: got done=%b pass=%b expected 0/1", done, pass); end
        @(negedge HCLK);
        n_checks++; if (wr_cnt - w0 !== 16 || rd_cnt - r0 !== 16) begin n_fail++; $display("FAIL lfsr_xfers: got wr=%0d rd=%0d expected 16/16", wr_cnt - w0, rd_cnt - r0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL lfsr_done_count: got %0d expected 1", done_cnt - d0); end
        n_checks++; if (mem[0] !== 32'h0000_ACE1 || mem[1] !== 32'h8020_5673) begin n_fail++; $display("FAIL lfsr_first_words: got %h %h expected 0000ace1 80205673", mem[0], mem[1]); end
        s = 32'hACE1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (mem[i] !== s) begin n_fail++; $display("FAIL lfsr_mem[%0d]: got %h expected %h", i, mem[i], s); end
            s = lfsr_model(s);
        end
    endtask

    task automatic test_addr_mismatch();
        int cyc, uns;
        waits = 0; err_wbeat = -1; flip_rbeat = 5;
        run_pass(2'd1, 0, cyc, uns);
        n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL addr_cycles: got %0d expected 65", cyc); end
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL addr_err_count: got %0d expected 1", err_count); end
        n_checks++; if (first_err_addr !== 32'h14) begin n_fail++; $display("FAIL addr_first_err: got %h expected 00000014", first_err_addr); end
        n_checks++; if (pass !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL addr_pass: got pass=%b berr=%b expected 0/0", pass, bus_err); end
        n_checks++; if (mem[5] !== 32'h14 || mem[15] !== 32'h3C) begin n_fail++; $display("FAIL addr_mem: got %h %h expected 00000014 0000003c", mem[5], mem[15]); end
        flip_rbeat = -1;
    endtask

    task automatic test_wait_states();
        int cyc, uns;
        waits = 3; err_wbeat = -1; flip_rbeat = -1;
        run_pass(2'd3, 0, cyc, uns);
        n_checks++; if (cyc !== 161) begin n_fail++; $display("FAIL wait_cycles: got %0d expected 161", cyc); end
        n_checks++; if (uns !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes expected 0", uns); end
        n_checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin n_fail++; $display("FAIL wait_result: got pass=%b err=%0d expected 1/0", pass, err_count); end
        n_checks++; if (mem[2] !== 32'hFFFF_FFFF || mem[3] !== 32'h0) begin n_fail++; $display("FAIL wait_mem: got %h %h expected ffffffff 00000000", mem[2], mem[3]); end
        waits = 0;
    endtask

    task automatic test_bus_error();
        int cyc, uns, w0, r0;
        waits = 0; flip_rbeat = -1;
        clear_mem();
        err_wbeat = 2;
        w0 = wr_cnt; r0 = rd_cnt;
        run_pass(2'd3, 0, cyc, uns);
        n_checks++; if (cyc !== 66) begin n_fail++; $display("FAIL berr_cycles: got %0d expected 66", cyc); end
        n_checks++; if (bus_err !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL berr_flags: got berr=%b pass=%b expected 1/0", bus_err, pass); end
        n_checks++; if (err_count !== 16'd1 || first_err_addr !== 32'h8) begin n_fail++; $display("FAIL berr_stale_read: got err=%0d addr=%h expected 1/00000008", err_count, first_err_addr); end
        @(negedge HCLK); @(negedge HCLK);
        n_checks++; if (rd_cnt - r0 !== 16 || wr_cnt - w0 !== 16) begin n_fail++; $display("FAIL berr_xfers: got wr=%0d rd=%0d expected 16/16", wr_cnt - w0, rd_cnt - r0); end
        err_wbeat = -1;
    endtask

    task automatic test_saturation();
        int cyc;
        @(negedge HCLK); start2 = 1'b1;
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge HCLK);
            start2 = 1'b0;
            cyc++;
            if (done2) break;
        end
        n_checks++; if (cyc !== 81) begin n_fail++; $display("FAIL sat_cycles: got %0d expected 81", cyc); end
        n_checks++; if (err_count2 !== 4'hF) begin n_fail++; $display("FAIL sat_err_count: got %h expected f", err_count2); end
        n_checks++; if (fea2 !== 32'h100 || pass2 !== 1'b0 || bus_err2 !== 1'b0) begin n_fail++; $display("FAIL sat_status: got addr=%h pass=%b berr=%b expected 00000100/0/0", fea2, pass2, bus_err2); end
    endtask

    task automatic test_reset_mid_pass();
        int cyc, uns, d0;
        bit found;
        waits = 0; err_wbeat = -1; flip_rbeat = 1;
        @(negedge HCLK); start = 1'b1; mode = 2'd0;
        @(negedge HCLK); start = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b10 && !HWRITE && HADDR == 32'h8) begin found = 1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_read_reached: got %b expected 1", found); end
        n_checks++; if (err_count !== 16'd1 || first_err_addr !== 32'h4) begin n_fail++; $display("FAIL mid_err_before_reset: got %0d/%h expected 1/00000004", err_count, first_err_addr); end
        HRESET = 1'b1;
        @(negedge HCLK);
        n_checks++; if ({busy, done, pass, bus_err} !== 4'b0 || HTRANS !== 2'b00 || HADDR !== 32'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got flags=%b htrans=%b haddr=%h expected 0/00/0", {busy, done, pass, bus_err}, HTRANS, HADDR); end
        n_checks++; if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_err: got %h/%h expected 0/0", err_count, first_err_addr); end
        @(negedge HCLK); HRESET = 1'b0;
        flip_rbeat = -1;
        d0 = done_cnt;
        run_pass(2'd0, 10, cyc, uns);
        n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL mid_second_cycles: got %0d expected 65", cyc); end
        n_checks++; if (pass !== 1'b1 || err_count !== 16'h0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL mid_second_pass: got pass=%b err=%0d berr=%b expected 1/0/0", pass, err_count, bus_err); end
        @(negedge HCLK); @(negedge HCLK);
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL mid_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_lfsr_pass();
        test_addr_mismatch();
        test_wait_states();
        test_bus_error();
        test_saturation();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
